// File: rtl/cgra_pkg.sv
// Shared definitions for the pw2 CGRA slice: opcodes, config feature codes
// and the layout of the 32-bit configuration address.
package cgra_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_PASS = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_LSHR = 4'd8
  } opcode_e;

  localparam logic [7:0] FEAT_OPCODE   = 8'hFF;
  localparam logic [7:0] FEAT_CONST    = 8'hF0;
  localparam logic [7:0] FEAT_IO       = 8'h00;
  localparam logic [7:0] CFG_REG_WRITE = 8'h00;

  localparam int ADDR_REG_MSB  = 31;
  localparam int ADDR_REG_LSB  = 24;
  localparam int ADDR_FEAT_MSB = 23;
  localparam int ADDR_FEAT_LSB = 16;
  localparam int ADDR_TILE_MSB = 15;
  localparam int ADDR_TILE_LSB = 0;

  typedef struct packed {
    logic [7:0]  reg_idx;
    logic [7:0]  feature;
    logic [15:0] tile;
  } cfg_addr_t;

  function automatic cfg_addr_t unpack_addr(input logic [31:0] addr);
    cfg_addr_t f;
    f.reg_idx = addr[ADDR_REG_MSB:ADDR_REG_LSB];
    f.feature = addr[ADDR_FEAT_MSB:ADDR_FEAT_LSB];
    f.tile    = addr[ADDR_TILE_MSB:ADDR_TILE_LSB];
    return f;
  endfunction

  // A write lands only when the register field is the write register and
  // both feature and tile match exactly.
  function automatic logic cfg_hit(input cfg_addr_t f, input logic [7:0] feat,
                                   input logic [15:0] tile);
    return (f.reg_idx == CFG_REG_WRITE) && (f.feature == feat) && (f.tile == tile);
  endfunction

endpackage

// File: rtl/cgra_pe.sv
// 16-bit processing element: opcode/constant config registers, ALU and the
// registered result pe_q.
module cgra_pe
  import cgra_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic [15:0] tile_id,
  input  logic [15:0] a,
  output logic [15:0] pe_q
);

  cfg_addr_t   addr_s;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] const_q, const_d;
  logic [15:0] pe_d;
  logic        unused_data_s;

  assign addr_s        = unpack_addr(cfg_addr);
  assign unused_data_s = ^cfg_data[31:16];

  // Config decode: at most one of the two PE registers is hit per cycle.
  always_comb begin
    opcode_d = opcode_q;
    const_d  = const_q;
    if (cfg_hit(addr_s, FEAT_OPCODE, tile_id)) begin
      opcode_d = cfg_data[3:0];
    end else if (cfg_hit(addr_s, FEAT_CONST, tile_id)) begin
      const_d = cfg_data[15:0];
    end else begin
      opcode_d = opcode_q;
      const_d  = const_q;
    end
  end

  // ALU; every result is taken modulo 2^16 and unused opcodes give zero.
  always_comb begin
    pe_d = 16'h0000;
    case (opcode_q)
      OP_ADD:  pe_d = a + const_q;
      OP_SUB:  pe_d = a - const_q;
      OP_MUL:  pe_d = a * const_q;
      OP_PASS: pe_d = a;
      OP_AND:  pe_d = a & const_q;
      OP_OR:   pe_d = a | const_q;
      OP_XOR:  pe_d = a ^ const_q;
      OP_SHL:  pe_d = a << const_q[3:0];
      OP_LSHR: pe_d = a >> const_q[3:0];
      default: pe_d = 16'h0000;
    endcase
  end

  // PE state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= 4'd0;
      const_q  <= 16'h0000;
      pe_q     <= 16'h0000;
    end else begin
      opcode_q <= opcode_d;
      const_q  <= const_d;
      pe_q     <= pe_d;
    end
  end

endmodule

// File: rtl/cgra_pw2_top.sv
// CGRA slice top: S2 input IO tile, one PE tile and the gated S0 output IO
// tile. Pad T0 is the bus MSB on both sides.
module cgra_pw2_top
  import cgra_pkg::*;
#(
  parameter logic [15:0] PE_TILE_ID = 16'h0001,
  parameter logic [15:0] IO_TILE_ID = 16'h0002
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  input  logic        pad_S2_T0_in,
  input  logic        pad_S2_T1_in,
  input  logic        pad_S2_T2_in,
  input  logic        pad_S2_T3_in,
  input  logic        pad_S2_T4_in,
  input  logic        pad_S2_T5_in,
  input  logic        pad_S2_T6_in,
  input  logic        pad_S2_T7_in,
  input  logic        pad_S2_T8_in,
  input  logic        pad_S2_T9_in,
  input  logic        pad_S2_T10_in,
  input  logic        pad_S2_T11_in,
  input  logic        pad_S2_T12_in,
  input  logic        pad_S2_T13_in,
  input  logic        pad_S2_T14_in,
  input  logic        pad_S2_T15_in,
  output logic        pad_S0_T0_out,
  output logic        pad_S0_T1_out,
  output logic        pad_S0_T2_out,
  output logic        pad_S0_T3_out,
  output logic        pad_S0_T4_out,
  output logic        pad_S0_T5_out,
  output logic        pad_S0_T6_out,
  output logic        pad_S0_T7_out,
  output logic        pad_S0_T8_out,
  output logic        pad_S0_T9_out,
  output logic        pad_S0_T10_out,
  output logic        pad_S0_T11_out,
  output logic        pad_S0_T12_out,
  output logic        pad_S0_T13_out,
  output logic        pad_S0_T14_out,
  output logic        pad_S0_T15_out,
  input  logic        tdi,
  input  logic        tms,
  input  logic        tck,
  input  logic        trst_n,
  output logic        tdo
);

  logic [15:0] in_q, in_d;
  logic        out_en_q, out_en_d;
  logic [15:0] pe_s;
  logic [15:0] bus_s;
  logic        unused_jtag_s;

  assign in_d = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
                 pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
                 pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
                 pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};

  // Output IO tile enable write.
  always_comb begin
    out_en_d = out_en_q;
    if (cfg_hit(unpack_addr(config_addr_in), FEAT_IO, IO_TILE_ID)) begin
      out_en_d = config_data_in[0];
    end else begin
      out_en_d = out_en_q;
    end
  end

  // Input capture and IO tile state.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      in_q     <= 16'h0000;
      out_en_q <= 1'b0;
    end else begin
      in_q     <= in_d;
      out_en_q <= out_en_d;
    end
  end

  cgra_pe u_pe (
    .clk      (clk_in),
    .rst      (reset_in),
    .cfg_addr (config_addr_in),
    .cfg_data (config_data_in),
    .tile_id  (PE_TILE_ID),
    .a        (in_q),
    .pe_q     (pe_s)
  );

  // The gate sits after the flop so clearing out_en blanks the pads at once.
  assign bus_s = out_en_q ? pe_s : 16'h0000;

  assign pad_S0_T0_out  = bus_s[15];
  assign pad_S0_T1_out  = bus_s[14];
  assign pad_S0_T2_out  = bus_s[13];
  assign pad_S0_T3_out  = bus_s[12];
  assign pad_S0_T4_out  = bus_s[11];
  assign pad_S0_T5_out  = bus_s[10];
  assign pad_S0_T6_out  = bus_s[9];
  assign pad_S0_T7_out  = bus_s[8];
  assign pad_S0_T8_out  = bus_s[7];
  assign pad_S0_T9_out  = bus_s[6];
  assign pad_S0_T10_out = bus_s[5];
  assign pad_S0_T11_out = bus_s[4];
  assign pad_S0_T12_out = bus_s[3];
  assign pad_S0_T13_out = bus_s[2];
  assign pad_S0_T14_out = bus_s[1];
  assign pad_S0_T15_out = bus_s[0];

  assign unused_jtag_s = ^{tdi, tms, tck, trst_n};
  assign tdo           = 1'b0;

endmodule

// File: tb/tb_cgra_pw2_top.sv
// Self-checking bench for cgra_pw2_top: a cycle-level model of the slice,
// checked every cycle, plus hand-computed literal expectations.
module tb_cgra_pw2_top;

  localparam logic [31:0] A_OP  = {8'h00, 8'hFF, 16'h0001};
  localparam logic [31:0] A_CB  = {8'h00, 8'hF0, 16'h0001};
  localparam logic [31:0] A_OE  = {8'h00, 8'h00, 16'h0002};
  localparam logic [31:0] A_NOP = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] cfg_addr, cfg_data;
  logic [15:0] pad_in;
  logic [15:0] pad_out;
  logic        tdi, tms, tck, trst_n;
  logic        tdo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: configuration and pipeline contents as seen after each edge.
  int          m_op;
  logic [15:0] m_const, m_in, m_pe;
  logic        m_oe;

  logic [31:0] bad_addr [7];

  cgra_pw2_top dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .config_addr_in(cfg_addr), .config_data_in(cfg_data),
    .pad_S2_T0_in(pad_in[15]),  .pad_S2_T1_in(pad_in[14]),
    .pad_S2_T2_in(pad_in[13]),  .pad_S2_T3_in(pad_in[12]),
    .pad_S2_T4_in(pad_in[11]),  .pad_S2_T5_in(pad_in[10]),
    .pad_S2_T6_in(pad_in[9]),   .pad_S2_T7_in(pad_in[8]),
    .pad_S2_T8_in(pad_in[7]),   .pad_S2_T9_in(pad_in[6]),
    .pad_S2_T10_in(pad_in[5]),  .pad_S2_T11_in(pad_in[4]),
    .pad_S2_T12_in(pad_in[3]),  .pad_S2_T13_in(pad_in[2]),
    .pad_S2_T14_in(pad_in[1]),  .pad_S2_T15_in(pad_in[0]),
    .pad_S0_T0_out(pad_out[15]), .pad_S0_T1_out(pad_out[14]),
    .pad_S0_T2_out(pad_out[13]), .pad_S0_T3_out(pad_out[12]),
    .pad_S0_T4_out(pad_out[11]), .pad_S0_T5_out(pad_out[10]),
    .pad_S0_T6_out(pad_out[9]),  .pad_S0_T7_out(pad_out[8]),
    .pad_S0_T8_out(pad_out[7]),  .pad_S0_T9_out(pad_out[6]),
    .pad_S0_T10_out(pad_out[5]), .pad_S0_T11_out(pad_out[4]),
    .pad_S0_T12_out(pad_out[3]), .pad_S0_T13_out(pad_out[2]),
    .pad_S0_T14_out(pad_out[1]), .pad_S0_T15_out(pad_out[0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] spec_op(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = a << (b % 16);
      8: r = a >> (b % 16);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [15:0] exp_out();
    return m_oe ? m_pe : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_const = 16'h0000; m_in = 16'h0000; m_pe = 16'h0000; m_oe = 1'b0;
  endtask

  // One clock: apply inputs, advance the model at the edge, return at negedge.
  task automatic cycle(input logic [31:0] addr, input logic [31:0] data, input logic [15:0] pad);
    cfg_addr = addr; cfg_data = data; pad_in = pad;
    @(posedge clk_in);
    if (reset_in) begin
      model_reset();
    end else begin
      m_pe = spec_op(m_op, int'(m_in), int'(m_const));
      m_in = pad;
      if (addr == A_OP)      m_op = int'(data[3:0]);
      else if (addr == A_CB) m_const = data[15:0];
      else if (addr == A_OE) m_oe = data[0];
    end
    @(negedge clk_in);
  endtask

  task automatic run_case(input string name, input int op, input logic [15:0] c,
                          input logic [15:0] din, input logic [15:0] exp);
    cycle(A_OP, op, din);
    cycle(A_CB, {16'h0000, c}, din);
    repeat (3) cycle(A_NOP, 32'h0, din);
    check(name, pad_out, exp);
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("bus_vs_model", pad_out, exp_out());
      check("tdo_zero", {15'd0, tdo}, 16'h0000);
    end
  end

  initial begin
    tdi = 1'b0; tms = 1'b1; tck = 1'b0; trst_n = 1'b1;
    bad_addr[0] = 32'h0000_0000;
    bad_addr[1] = {8'h00, 8'hFF, 16'h0003};
    bad_addr[2] = {8'h01, 8'hFF, 16'h0001};
    bad_addr[3] = {8'h00, 8'hF0, 16'h0002};
    bad_addr[4] = {8'h00, 8'h00, 16'h0001};
    bad_addr[5] = {8'h02, 8'h00, 16'h0002};
    bad_addr[6] = {8'h00, 8'hFE, 16'h0001};
    model_reset();

    reset_in = 1'b1; cfg_addr = A_NOP; cfg_data = 32'h0; pad_in = 16'h0180;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_bus", pad_out, 16'h0000);
    check("reset_tdo", {15'd0, tdo}, 16'h0000);
    reset_in = 1'b0;
    chk_en = 1'b1;

    check("model_pin_pw2", spec_op(2, 16'h0180, 2), 16'h0300);
    check("model_pin_wrap", spec_op(7, 16'h8001, 1), 16'h0002);

    // pw2 via multiply, held for 300 cycles
    cycle(A_OP, 32'd2, 16'h0180);
    cycle(A_CB, 32'd2, 16'h0180);
    cycle(A_OE, 32'd1, 16'h0180);
    repeat (300) cycle(A_NOP, 32'h0, 16'h0180);
    check("pw2_bus", pad_out, 16'h0300);
    check("pw2_T6_T7", {14'd0, pad_out[9], pad_out[8]}, 16'h0003);

    // writes that must be ignored
    for (int i = 0; i < 70; i++)
      cycle(bad_addr[i % 7], $urandom | 32'h1, 16'h0180);
    check("filter_hold", pad_out, 16'h0300);

    run_case("op_add",    0, 16'h0003, 16'h1234, 16'h1237);
    run_case("op_sub",    1, 16'h0003, 16'h0001, 16'hFFFE);
    run_case("op_mul_ov", 2, 16'h0002, 16'h8000, 16'h0000);
    run_case("op_pass",   3, 16'h5555, 16'hBEEF, 16'hBEEF);
    run_case("op_and",    4, 16'h0FF0, 16'h1234, 16'h0230);
    run_case("op_or",     5, 16'h0FF0, 16'h1234, 16'h1FF4);
    run_case("op_xor",    6, 16'h0FF0, 16'h1234, 16'h1DC4);
    run_case("shl_pw2",   7, 16'h0001, 16'h8001, 16'h0002);
    run_case("shl_mask",  7, 16'h0014, 16'h0001, 16'h0010);
    run_case("op_lshr",   8, 16'h0004, 16'h8000, 16'h0800);
    run_case("op_9",      9, 16'h0003, 16'h1234, 16'h0000);
    run_case("op_15",    15, 16'h0003, 16'hFFFF, 16'h0000);
    run_case("pw2_again", 2, 16'h0002, 16'h0180, 16'h0300);

    // output gating
    cycle(A_OE, 32'd0, 16'h0180);
    check("gate_off", pad_out, 16'h0000);
    cycle(A_NOP, 32'h0, 16'h0180);
    check("gate_off_hold", pad_out, 16'h0000);
    cycle(A_OE, 32'd1, 16'h0180);
    check("gate_on", pad_out, 16'h0300);

    // asynchronous reset between edges
    #2 reset_in = 1'b1;
    #1 check("async_reset", pad_out, 16'h0000);
    model_reset();
    @(negedge clk_in);
    repeat (2) cycle(A_NOP, 32'h0, 16'h0180);
    reset_in = 1'b0;
    repeat (10) cycle(A_NOP, 32'h0, 16'h0180);
    check("post_reset_zero", pad_out, 16'h0000);
    cycle(A_OP, 32'd2, 16'h0180);
    cycle(A_CB, 32'd2, 16'h0180);
    cycle(A_OE, 32'd1, 16'h0180);
    repeat (2) cycle(A_NOP, 32'h0, 16'h0180);
    check("reconfig_pw2", pad_out, 16'h0300);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
